// File: rtl/rx_phase_slicer.sv
// rx_phase_slicer: receive-side symbol-timing recovery and hard slicer for a
// shaped BPSK stream at UPSAMPLE samples per symbol.
//
// Energy (sum of |sample|) is accumulated separately for each sampling phase
// over a window of ACC_SYMBOLS symbols. At every window end the phase with the
// most energy is selected. After the first window the block slices the sample
// at that phase of every symbol into a hard bit.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   enable    sample strobe; all state advances only when high
//   rx_in     signed IN_NBITS input sample (Q(IN_NBITS, IN_NBITS-1))
//   rx_bit    sliced bit (1 for sample >= 0), held between strobes
//   rx_valid  one-cycle strobe marking a new rx_bit
//   phase     currently selected sampling phase
//   locked    high once the first energy window has been evaluated
module rx_phase_slicer #(
    parameter int unsigned UPSAMPLE    = 4,
    parameter int unsigned IN_NBITS    = 8,
    parameter int unsigned ACC_SYMBOLS = 1024,
    localparam int unsigned PH_NBITS   = $clog2(UPSAMPLE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic signed [IN_NBITS-1:0] rx_in,
    output logic                       rx_bit,
    output logic                       rx_valid,
    output logic [PH_NBITS-1:0]        phase,
    output logic                       locked
);

    localparam int unsigned SYM_NBITS = $clog2(ACC_SYMBOLS);
    localparam int unsigned ACC_NBITS = IN_NBITS + SYM_NBITS;

    localparam logic [PH_NBITS-1:0]  LAST_PH  = PH_NBITS'(UPSAMPLE - 1);
    localparam logic [SYM_NBITS-1:0] LAST_SYM = SYM_NBITS'(ACC_SYMBOLS - 1);

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [PH_NBITS-1:0]     sample_cnt;
    logic [SYM_NBITS-1:0]    sym_cnt;
    logic [ACC_NBITS-1:0]    acc_q [UPSAMPLE];

    logic [IN_NBITS-1:0]     mag;
    logic [ACC_NBITS-1:0]    mag_ext;
    logic [ACC_NBITS-1:0]    cand [UPSAMPLE];
    logic [ACC_NBITS-1:0]    best_val;
    logic [PH_NBITS-1:0]     best_idx;
    logic [PH_NBITS-1:0]     new_phase;
    logic                    sym_end;
    logic                    win_end;
    logic                    slice_hit;

    // Magnitude as unsigned: the most negative input maps to 2^(IN_NBITS-1)
    // exactly, which still fits the unsigned IN_NBITS range.
    always_comb begin
        mag = rx_in[IN_NBITS-1] ? (IN_NBITS'(0) - $unsigned(rx_in)) : $unsigned(rx_in);
    end

    assign mag_ext = ACC_NBITS'(mag);

    assign sym_end   = enable && (sample_cnt == LAST_PH);
    assign win_end   = sym_end && (sym_cnt == LAST_SYM);
    assign slice_hit = (state_q == TRACK) && enable && (sample_cnt == phase);

    // Candidate energies at window end; the window-end sample always belongs
    // to the last phase, so only that entry picks up the current magnitude.
    always_comb begin
        for (int k = 0; k < int'(UPSAMPLE); k++) begin
            cand[k] = acc_q[k];
            if (k == int'(UPSAMPLE) - 1) begin
                cand[k] = acc_q[k] + mag_ext;
            end
        end
    end

    // Argmax with lowest-index preference; in TRACK the current phase is kept
    // whenever it is among the maxima, to avoid dithering between equal phases.
    always_comb begin
        best_val = cand[0];
        best_idx = '0;
        for (int k = 1; k < int'(UPSAMPLE); k++) begin
            if (cand[k] > best_val) begin
                best_val = cand[k];
                best_idx = PH_NBITS'(k);
            end
        end
        new_phase = best_idx;
        if ((state_q == TRACK) && (cand[phase] == best_val)) begin
            new_phase = phase;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACQ;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one acquisition window, then tracking until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACQ:     if (win_end) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = ACQ;
        endcase
    end

    // Sample-phase and symbol counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt <= '0;
            sym_cnt    <= '0;
        end else if (enable) begin
            sample_cnt <= (sample_cnt == LAST_PH) ? '0 : sample_cnt + PH_NBITS'(1);
            if (sym_end) begin
                sym_cnt <= sym_cnt + SYM_NBITS'(1);
            end
        end
    end

    // Per-phase energy accumulators; cleared at window end so the next window
    // starts on the following enabled sample with no dead cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(UPSAMPLE); k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(UPSAMPLE); k++) begin
                if (win_end) begin
                    acc_q[k] <= '0;
                end else if (enable && (sample_cnt == PH_NBITS'(k))) begin
                    acc_q[k] <= acc_q[k] + mag_ext;
                end
            end
        end
    end

    // Phase selection and lock flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase  <= '0;
            locked <= 1'b0;
        end else if (win_end) begin
            phase  <= new_phase;
            locked <= 1'b1;
        end
    end

    // Hard slicer; uses the registered phase, so the window-end sample is
    // still sliced with the previous phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_bit   <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= slice_hit;
            if (slice_hit) begin
                rx_bit <= ~rx_in[IN_NBITS-1];
            end
        end
    end

endmodule

// File: tb/tb_rx_phase_slicer.sv
// Directed bench for rx_phase_slicer with an 8-symbol window (32 samples).
module tb_rx_phase_slicer;

    localparam int unsigned NSYM = 8;

    logic              clk;
    logic              rst;
    logic              enable;
    logic signed [7:0] rx_in;
    logic              rx_bit;
    logic              rx_valid;
    logic [1:0]        phase;
    logic              locked;

    int vectors;
    int miscompares;

    rx_phase_slicer #(
        .UPSAMPLE   (4),
        .IN_NBITS   (8),
        .ACC_SYMBOLS(NSYM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .rx_in   (rx_in),
        .rx_bit  (rx_bit),
        .rx_valid(rx_valid),
        .phase   (phase),
        .locked  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle; outputs are sampled 1 ns after the capturing edge.
    task automatic tick(input logic en, input logic [7:0] x);
        enable = en;
        rx_in  = x;
        @(posedge clk);
        #1;
    endtask

    // One enabled sample, optionally preceded by a random run of idle cycles.
    task automatic sample(input logic [7:0] x, input bit gapped);
        if (gapped) begin
            int n;
            n = $urandom_range(0, 4);
            for (int g = 0; g < n; g++) begin
                tick(1'b0, 8'($urandom));
                chk("gap_valid", 32'(rx_valid), 32'd0);
            end
        end
        tick(1'b1, x);
    endtask

    // A full window of identical symbols. vph is the phase expected to be
    // sliced during this window (4 = none), vbit its expected bit.
    task automatic window(input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3,
                          input int vph, input logic vbit, input bit gapped,
                          input logic [1:0] pre_ph, input logic pre_lk,
                          input logic [1:0] post_ph);
        logic [7:0] v [4];
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        for (int s = 0; s < int'(NSYM); s++) begin
            for (int k = 0; k < 4; k++) begin
                if (s == int'(NSYM) - 1 && k == 3) begin
                    chk("pre_locked", 32'(locked), 32'(pre_lk));
                    chk("pre_phase", 32'(phase), 32'(pre_ph));
                end
                sample(v[k], gapped);
                chk("valid", 32'(rx_valid), 32'(k == vph));
                if (k == vph) chk("bit", 32'(rx_bit), 32'(vbit));
            end
        end
        chk("locked", 32'(locked), 32'd1);
        chk("phase", 32'(phase), 32'(post_ph));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        enable      = 1'b0;
        rx_in       = '0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 6; i++) tick(1'($urandom), 8'($urandom));
        chk("rst_bit", 32'(rx_bit), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);

        // Release, then idle cycles leave everything unchanged.
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'($urandom));
            chk("idle_valid", 32'(rx_valid), 32'd0);
        end
        chk("idle_bit", 32'(rx_bit), 32'd0);
        chk("idle_phase", 32'(phase), 32'd0);
        chk("idle_locked", 32'(locked), 32'd0);

        // Acquisition: energy only on phase 2; lock on the 32nd sample.
        window(8'd0, 8'd0, 8'd64, 8'd0, 4, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2);
        // Tracking at phase 2, bit 1 once per symbol.
        window(8'd0, 8'd0, 8'd64, 8'd0, 2, 1'b1, 1'b0, 2'd2, 1'b1, 2'd2);

        // Magnitude edge: |-128| = 128 beats 127 -> phase 1 (1024 > 1016).
        window(8'd0, 8'h80, 8'd0, 8'd127, 2, 1'b1, 1'b0, 2'd2, 1'b1, 2'd1);
        window(8'd0, 8'h80, 8'd0, 8'd127, 1, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1);

        // Partial window with strong phase-3 energy, then async reset.
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                sample((k == 3) ? 8'd100 : 8'd0, 1'b0);
                chk("part_valid", 32'(rx_valid), 32'(k == 1));
            end
        end
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_phase", 32'(phase), 32'd0);
        chk("mid_rst_valid", 32'(rx_valid), 32'd0);
        tick(1'b1, 8'd50);
        tick(1'b1, 8'd50);
        rst = 1'b1;

        // Fresh acquisition on all-zero input: tie -> phase 0, lock only after
        // a full window (leftover phase-3 energy must be gone).
        window(8'd0, 8'd0, 8'd0, 8'd0, 4, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

        // TRACK tie between phases 0 and 1 while at 0 -> stays 0.
        window(8'd10, 8'd10, 8'd0, 8'd0, 0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        // Phase 3 only, with gapped enable: switch after exactly 32 enabled samples.
        window(8'd0, 8'd0, 8'd0, 8'd10, 0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd3);
        // TRACK tie between phases 0 and 3 while at 3 -> stays 3.
        window(8'd20, 8'd0, 8'd0, 8'd20, 3, 1'b1, 1'b0, 2'd3, 1'b1, 2'd3);
        // Negative sample at the tracked phase slices to 0.
        window(8'd0, 8'd0, 8'd0, 8'hEC, 3, 1'b0, 1'b0, 2'd3, 1'b1, 2'd3);

        // Idle after the last sample: strobe drops, bit holds.
        tick(1'b0, 8'd77);
        chk("tail_valid", 32'(rx_valid), 32'd0);
        chk("tail_bit", 32'(rx_bit), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_phase_slicer.md
Name: rx_phase_slicer

Overview:
- Receive-side front end that consumes the 8-bit shaped BPSK sample stream produced by the tx polyphase filter, one sample per enable, at UPSAMPLE samples per symbol.
- Finds the best sampling phase by accumulating |sample| per phase over a window of ACC_SYMBOLS symbols, then downsamples at that phase and slices to hard bits.
- Feeds the downstream bit/BER checker.

Parameters:
- UPSAMPLE, 4, samples per symbol; power of two.
- IN_NBITS, 8, width of the signed input sample, Q(8,7).
- ACC_SYMBOLS, 1024, symbols per energy window; power of two, at least 2.
- ACC_NBITS, IN_NBITS+$clog2(ACC_SYMBOLS), per-phase accumulator width (localparam).
- PH_NBITS, $clog2(UPSAMPLE), width of the phase index (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  sample strobe; all state advances only on cycles with enable=1.
- rx_in  in  IN_NBITS  signed input sample from the tx stage.
- rx_bit  out  1  sliced bit; 1 when the sample is >=0, 0 when it is <0.
- rx_valid  out  1  one-cycle strobe marking rx_bit valid.
- phase  out  PH_NBITS  currently selected sampling phase.
- locked  out  1  high once the first window has been evaluated.

Behaviour:
- Reset (rst=0, async): rx_bit=0, rx_valid=0, phase=0, locked=0, sample_cnt=0, sym_cnt=0, all accumulators 0, FSM=ACQ. Reset mid-window discards all partial accumulation.
- sample_cnt (PH_NBITS bits): increments on each enabled cycle and wraps UPSAMPLE-1 -> 0. sym_cnt ($clog2(ACC_SYMBOLS) bits): increments when enable && sample_cnt==UPSAMPLE-1, wrapping naturally.
- Magnitude: mag = rx_in>=0 ? rx_in : -rx_in, as an unsigned IN_NBITS value. -128 gives 128 exactly, with no wrap.
- Accumulate: on an enabled cycle, acc[sample_cnt] <= acc[sample_cnt] + mag. Max total is 2^(IN_NBITS-1)*ACC_SYMBOLS, which fits ACC_NBITS with no overflow.
- Window end: an enabled cycle with sample_cnt==UPSAMPLE-1 and sym_cnt==ACC_SYMBOLS-1.
  - Compute cand[k] = acc[k] + (k==UPSAMPLE-1 ? mag : 0); the current sample is included.
  - phase <= argmax(cand).
  - All acc <= 0 at the same edge, and the next window starts immediately with no dead cycle.
- Tie-break:
  - In ACQ, ties resolve to the lowest index.
  - In TRACK, if cand[phase] equals the maximum, phase is unchanged; otherwise the lowest maximal index wins.
- FSM:
  - ACQ -> TRACK at the first window end; locked <= 1 at the same edge.
  - TRACK stays in TRACK and re-evaluates every window. Only reset returns the FSM to ACQ.
- Slicing: in TRACK, on an enabled cycle with sample_cnt==phase (registered value), rx_bit <= ~rx_in[IN_NBITS-1] and rx_valid <= 1. On every other cycle rx_valid <= 0 and rx_bit holds.
- Latency: one clock from the sample to rx_valid/rx_bit.
- Window-end sample: slicing on this sample uses the old phase. The new phase applies from the next enabled sample (sample_cnt=0).
- ACQ: rx_valid is always 0.
- Gaps: enable=0 freezes all counters, accumulators and the FSM; rx_valid=0 during gaps.

Test Plan:
- Reset: hold rst=0 with random rx_in/enable -> rx_bit=0, rx_valid=0, phase=0, locked=0. Release and apply 10 cycles of enable=0 -> all outputs unchanged.
- Acquisition (ACC_SYMBOLS=8): continuous enable; rx_in=+64 at sample_cnt 2, 0 elsewhere -> locked rises after the 32nd sample edge with phase=2. Afterwards rx_valid pulses every 4th cycle, one clock after each phase-2 sample, with rx_bit=1.
- Magnitude edge (ACC_SYMBOLS=8): phase 1 fed -128, phase 3 fed +127, others 0 -> phase=1 (1024 > 1016). Sliced bits are 0.
- Ties: all-zero input -> phase=0 after the first window. Then drive +10 on phase 1 and +10 on phase 0 for a window -> phase stays 0. Then drive phase 3 only -> phase=3 at the next window end.
- Gapped enable plus mid-window reset: random enable duty of 30% -> window end occurs after exactly 4*ACC_SYMBOLS enabled samples. Pulse rst low mid-window -> locked=0, and a full new window is needed to relock.
- End-to-end: PRBS9 -> tx -> rx_phase_slicer with ACC_SYMBOLS=1024 -> after lock, the rx_bit stream equals the PRBS delayed by a fixed latency with zero errors over 10000 bits.
